// File: rtl/store_rmw_if.sv
// Store request channel plus word-wide data-memory port for store_rmw.
// The slave modport is the store unit; the master is the core/memory side.
interface store_rmw_if #(
  parameter int ADDR_W = 32
);
  logic              st_valid;
  logic              st_ready;
  logic [ADDR_W-1:0] st_addr;
  logic [31:0]       st_data;
  logic [1:0]        st_size;
  logic [ADDR_W-3:0] mem_addr;
  logic              mem_re;
  logic [31:0]       mem_rdata;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic              misalign;

  modport master (
    output st_valid, st_addr, st_data, st_size, mem_rdata,
    input  st_ready, mem_addr, mem_re, mem_we, mem_wdata, busy, done, misalign
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_size, mem_rdata,
    output st_ready, mem_addr, mem_re, mem_we, mem_wdata, busy, done, misalign
  );
endinterface

// File: rtl/store_rmw.sv
// Store unit for a word-only data memory: sub-word stores become read-merge-write,
// misaligned or reserved-size stores are rejected with a misalign pulse.
//
//   state | meaning
//   IDLE  | ready for a store request
//   READ  | mem_re issued for the target word (sub-word store)
//   MERGE | read data arrives; addressed lane(s) replaced
//   WRITE | mem_we with full word, done pulse
//   ERR   | rejected request, misalign pulse, no memory access
module store_rmw #(
  parameter int ADDR_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  store_rmw_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, ERR} state_t;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  state_t            state, state_nxt;
  logic [ADDR_W-3:0] addr_q;
  logic [1:0]        lane_q;
  logic [1:0]        size_q;
  logic [31:0]       data_q;
  logic [31:0]       merged_q;
  logic              accept;
  logic              bad_req;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old,
                                              input logic [31:0] dat,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane);
    logic [31:0] w;
    w = old;
    case (size)
      SZ_BYTE: begin
        case (lane)
          2'd0:    w[7:0]   = dat[7:0];
          2'd1:    w[15:8]  = dat[7:0];
          2'd2:    w[23:16] = dat[7:0];
          default: w[31:24] = dat[7:0];
        endcase
      end
      SZ_HALF: begin
        if (lane[1]) w[31:16] = dat[15:0];
        else         w[15:0]  = dat[15:0];
      end
      default: w = old;
    endcase
    return w;
  endfunction

  assign accept = bus.st_valid && bus.st_ready;

  always_comb begin
    bad_req = 1'b0;
    case (bus.st_size)
      SZ_WORD: bad_req = (bus.st_addr[1:0] != 2'b00);
      SZ_HALF: bad_req = bus.st_addr[0];
      SZ_BYTE: bad_req = 1'b0;
      default: bad_req = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Outputs are forced low while rst is high so an in-flight store can never write.
  always_comb begin
    state_nxt     = state;
    bus.st_ready  = 1'b0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.misalign  = 1'b0;
    bus.mem_re    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (!rst) begin
      bus.busy = (state != IDLE);
      case (state)
        IDLE: begin
          bus.st_ready = 1'b1;
          if (bus.st_valid) begin
            if (bad_req)                    state_nxt = ERR;
            else if (bus.st_size == SZ_WORD) state_nxt = WRITE;
            else                            state_nxt = READ;
          end
        end
        READ: begin
          bus.mem_re   = 1'b1;
          bus.mem_addr = addr_q;
          state_nxt    = MERGE;
        end
        MERGE: begin
          bus.mem_addr = addr_q;
          state_nxt    = WRITE;
        end
        WRITE: begin
          bus.mem_we    = 1'b1;
          bus.done      = 1'b1;
          bus.mem_addr  = addr_q;
          bus.mem_wdata = (size_q == SZ_WORD) ? data_q : merged_q;
          state_nxt     = IDLE;
        end
        ERR: begin
          bus.misalign = 1'b1;
          state_nxt    = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      lane_q   <= '0;
      size_q   <= '0;
      data_q   <= '0;
      merged_q <= '0;
    end else begin
      if (accept) begin
        addr_q <= bus.st_addr[ADDR_W-1:2];
        lane_q <= bus.st_addr[1:0];
        size_q <= bus.st_size;
        data_q <= bus.st_data;
      end
      if (state == MERGE) merged_q <= merge_lanes(bus.mem_rdata, data_q, size_q, lane_q);
    end
  end
endmodule

// File: tb/tb_store_rmw.sv
// Directed bench for store_rmw with a word memory model and event scoreboards
// for reads, writes and misalign pulses (cycle, address, data).
module tb_store_rmw;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  store_rmw_if #(.ADDR_W(32)) bus ();
  store_rmw #(.ADDR_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int          cyc;
    logic [29:0] addr;
    logic [31:0] data;
  } ev_t;

  ev_t re_q[$];
  ev_t we_q[$];
  ev_t mis_q[$];

  logic [31:0] mem [logic [29:0]];
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [29:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0;
  endfunction

  function automatic logic [31:0] model_merge(input logic [31:0] old, input logic [31:0] d,
                                              input logic [1:0] s, input logic [1:0] lane);
    logic [31:0] mask;
    int          sh;
    mask = (s == 2'b10) ? 32'h0000_00FF : 32'h0000_FFFF;
    sh   = 8 * int'(lane);
    return (old & ~(mask << sh)) | ((d & mask) << sh);
  endfunction

  // memory: one-cycle read latency, garbage on mem_rdata when no read was issued
  always @(posedge clk) begin
    cyc++;
    if (bus.mem_re) bus.mem_rdata <= mem_rd(bus.mem_addr);
    else            bus.mem_rdata <= $urandom;
    if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      ev_t e;
      if (bus.mem_we || bus.done) begin
        if (we_q.size() == 0) chk("unexpected_write", {31'd0, bus.mem_we | bus.done}, 32'd0);
        else begin
          e = we_q.pop_front();
          chk("we_cycle", cyc, e.cyc);
          chk("we_strobe", {31'd0, bus.mem_we}, 32'd1);
          chk("done_pulse", {31'd0, bus.done}, 32'd1);
          chk("we_addr", {2'b00, bus.mem_addr}, {2'b00, e.addr});
          chk("we_data", bus.mem_wdata, e.data);
        end
      end else begin
        chk("wdata_idle", bus.mem_wdata, 32'd0);
      end
      if (bus.mem_re) begin
        if (re_q.size() == 0) chk("unexpected_read", {31'd0, bus.mem_re}, 32'd0);
        else begin
          e = re_q.pop_front();
          chk("re_cycle", cyc, e.cyc);
          chk("re_addr", {2'b00, bus.mem_addr}, {2'b00, e.addr});
          chk("re_we_excl", {31'd0, bus.mem_we}, 32'd0);
        end
      end
      if (bus.misalign) begin
        if (mis_q.size() == 0) chk("unexpected_misalign", {31'd0, bus.misalign}, 32'd0);
        else begin
          e = mis_q.pop_front();
          chk("mis_cycle", cyc, e.cyc);
        end
      end
    end
  end

  function automatic bit is_bad(input logic [31:0] a, input logic [1:0] s);
    return (s == 2'b11) || (s == 2'b00 && a[1:0] != 2'b00) || (s == 2'b01 && a[0]);
  endfunction

  task automatic push_expect(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                             input int acc, input bit abort);
    ev_t e;
    e.addr = a[31:2];
    e.data = 32'h0;
    if (is_bad(a, s)) begin
      e.cyc = acc + 1;
      mis_q.push_back(e);
    end else if (s == 2'b00) begin
      e.cyc  = acc + 1;
      e.data = d;
      if (!abort) we_q.push_back(e);
    end else begin
      e.cyc = acc + 1;
      re_q.push_back(e);
      e.cyc  = acc + 3;
      e.data = model_merge(mem_rd(a[31:2]), d, s, a[1:0]);
      if (!abort) we_q.push_back(e);
    end
  endtask

  // Presents one request, waits (bounded) for acceptance, then scrambles the inputs.
  // Returns in the cycle after acceptance.
  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                      input bit abort, output int acc);
    bit got;
    got = 1'b0;
    acc = -1;
    @(negedge clk);
    bus.st_valid = 1'b1;
    bus.st_addr  = a;
    bus.st_data  = d;
    bus.st_size  = s;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (bus.st_ready === 1'b1) begin
        acc = cyc;
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) chk("accept_timeout", {31'd0, bus.st_ready}, 32'd1);
    else      push_expect(a, d, s, acc, abort);
    @(negedge clk);
    bus.st_valid = 1'b0;
    bus.st_addr  = $urandom;
    bus.st_data  = $urandom;
    bus.st_size  = 2'($urandom);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          acc;
    int          b2b_acc[3];
    int          n;
    logic [31:0] ra[3];
    logic [31:0] rd[3];
    logic [1:0]  rs[3];
    logic [31:0] ta[3];
    logic [31:0] td[3];
    logic [1:0]  ts[3];

    bus.st_valid  = 1'b0;
    bus.st_addr   = '0;
    bus.st_data   = '0;
    bus.st_size   = '0;
    bus.mem_rdata = '0;
    mem[30'h400]  = 32'h1122_3344;
    mem[30'h800]  = 32'hCAFE_F00D;
    mem[30'h1001] = 32'hA5A5_A5A5;

    // reset state, with a request pending that must not be taken
    rst = 1'b1;
    repeat (2) @(negedge clk);
    bus.st_valid = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_ready",    {31'd0, bus.st_ready}, 32'd0);
    chk("rst_busy",     {31'd0, bus.busy}, 32'd0);
    chk("rst_done",     {31'd0, bus.done}, 32'd0);
    chk("rst_misalign", {31'd0, bus.misalign}, 32'd0);
    chk("rst_re",       {31'd0, bus.mem_re}, 32'd0);
    chk("rst_we",       {31'd0, bus.mem_we}, 32'd0);
    chk("rst_addr",     {2'b00, bus.mem_addr}, 32'd0);
    chk("rst_wdata",    bus.mem_wdata, 32'd0);
    bus.st_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", {31'd0, bus.st_ready}, 32'd1);
    mon_en = 1'b1;

    // sb / sh / sw reference cases
    send(32'h0000_1002, 32'hFFFF_FFAB, 2'b10, 1'b0, acc);
    #1;
    chk("sb_busy", {31'd0, bus.busy}, 32'd1);
    send(32'h0000_2002, 32'h0000_BEEF, 2'b01, 1'b0, acc);
    send(32'h0000_3000, 32'hDEAD_BEEF, 2'b00, 1'b0, acc);
    repeat (4) @(negedge clk);
    chk("mem_sb_result", mem_rd(30'h400), 32'h11AB_3344);
    chk("mem_sh_result", mem_rd(30'h800), 32'hBEEF_F00D);

    // rejected requests
    ta = '{32'h0000_1001, 32'h0000_1002, 32'h0000_1000};
    ts = '{2'b01, 2'b00, 2'b11};
    for (int i = 0; i < 3; i++) begin
      send(ta[i], 32'h1234_5678, ts[i], 1'b0, acc);
      #1;
      chk("err_busy", {31'd0, bus.busy}, 32'd1);
      chk("err_notready", {31'd0, bus.st_ready}, 32'd0);
      @(negedge clk);
      #1;
      chk("err_ready_again", {31'd0, bus.st_ready}, 32'd1);
    end

    // more lane patterns on words already written
    ta = '{32'h0000_2000, 32'h0000_2003, 32'h0000_3000};
    td = '{32'hABCD_EF77, 32'h0000_0099, 32'hFFFF_1357};
    ts = '{2'b10, 2'b10, 2'b01};
    for (int i = 0; i < 3; i++) send(ta[i], td[i], ts[i], 1'b0, acc);
    repeat (4) @(negedge clk);
    chk("mem_lane_mix", mem_rd(30'h800), 32'h99EF_F077);
    chk("mem_sh_low",   mem_rd(30'hC00), 32'hDEAD_1357);

    // reset during MERGE abandons the store
    send(32'h0000_1003, 32'h0000_00EE, 2'b10, 1'b1, acc);
    @(negedge clk);
    #1;
    chk("abort_in_merge", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_we", {31'd0, bus.mem_we}, 32'd0);
    chk("abort_ready", {31'd0, bus.st_ready}, 32'd0);
    @(negedge clk);
    #1;
    chk("abort_we2", {31'd0, bus.mem_we}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    rst = 1'b0;
    #1;
    chk("abort_ready_after", {31'd0, bus.st_ready}, 32'd1);
    chk("abort_mem_kept", mem_rd(30'h400), 32'h11AB_3344);

    // st_valid held high across sw, sb, sw
    ra = '{32'h0000_4000, 32'h0000_4005, 32'h0000_4008};
    rd = '{32'h0123_4567, 32'hFFFF_FF5A, 32'h89AB_CDEF};
    rs = '{2'b00, 2'b10, 2'b00};
    n  = 0;
    @(negedge clk);
    bus.st_valid = 1'b1;
    bus.st_addr  = ra[0];
    bus.st_data  = rd[0];
    bus.st_size  = rs[0];
    for (int c = 0; c < 30 && n < 3; c++) begin
      #1;
      if (bus.st_ready === 1'b1) begin
        b2b_acc[n] = cyc;
        push_expect(ra[n], rd[n], rs[n], cyc, 1'b0);
        n++;
      end
      @(negedge clk);
      if (n < 3) begin
        bus.st_addr = ra[n];
        bus.st_data = rd[n];
        bus.st_size = rs[n];
      end else begin
        bus.st_valid = 1'b0;
      end
    end
    bus.st_valid = 1'b0;
    chk("b2b_accepts", n, 3);
    if (n == 3) begin
      chk("b2b_acc1", b2b_acc[1] - b2b_acc[0], 2);
      chk("b2b_acc2", b2b_acc[2] - b2b_acc[0], 6);
    end

    repeat (6) @(negedge clk);
    chk("mem_b2b_sb", mem_rd(30'h1001), 32'hA5A5_5AA5);
    chk("we_q_drained",  we_q.size(), 0);
    chk("re_q_drained",  re_q.size(), 0);
    chk("mis_q_drained", mis_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/store_rmw.md
STORE_RMW -- requirements
Module: store_rmw

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning byte-address width.
REQ-002 The block SHALL have port clk, input, 1, meaning the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, meaning reset, which is synchronous and active-high.
REQ-004 The block SHALL have port st_valid, input, 1, meaning a store request is present.
REQ-005 The block SHALL have port st_ready, output, 1, meaning a request is accepted this cycle; a request is taken when st_valid&&st_ready.
REQ-006 The block SHALL have port st_addr, input, ADDR_W, meaning the byte address of the store.
REQ-007 The block SHALL have port st_data, input, 32, meaning store data, right-justified (byte in [7:0], half in [15:0]).
REQ-008 The block SHALL have port st_size, input, 2, meaning 00 word (sw), 01 half (sh), 10 byte (sb), 11 reserved; this is the same encoding as the load-size field.
REQ-009 The block SHALL have port mem_addr, output, ADDR_W-2, meaning the word address to data memory.
REQ-010 The block SHALL have port mem_re, output, 1, meaning read strobe; mem_rdata is valid exactly one cycle after mem_re.
REQ-011 The block SHALL have port mem_rdata, input, 32, meaning memory read data.
REQ-012 The block SHALL have port mem_we, output, 1, meaning full-word write strobe; memory has no byte enables.
REQ-013 The block SHALL have port mem_wdata, output, 32, meaning write data.
REQ-014 The block SHALL have port busy, output, 1, meaning pipeline stall, high whenever state != IDLE.
REQ-015 The block SHALL have port done, output, 1, meaning a one-cycle pulse when a store is written.
REQ-016 The block SHALL have port misalign, output, 1, meaning a one-cycle pulse when a request is rejected.

Function
REQ-017 The FSM SHALL have states IDLE, READ, MERGE, WRITE, ERR; st_ready SHALL be 1 only in IDLE with rst=0.
REQ-018 On accept, the block SHALL register addr, data, size and lane (addr[1:0]).
REQ-019 Lanes SHALL be little-endian: byte lane n is bits [8n+7:8n]; a half at addr[1]=0 is [15:0], at addr[1]=1 it is [31:16].
REQ-020 Misalignment SHALL be defined as: word with addr[1:0]!=0, half with addr[0]=1, or size=11; on accept of such a request, go IDLE->ERR, pulse misalign in ERR, issue no mem_re/mem_we, then return to IDLE.
REQ-021 For an aligned word store, the FSM SHALL go IDLE->WRITE; WRITE drives mem_we=1 and mem_wdata=stored data for one cycle, with done=1 in the same cycle, then returns to IDLE; latency is 1 cycle after accept.
REQ-022 For an aligned half or byte store, the FSM SHALL go IDLE->READ (mem_re=1, one cycle) ->MERGE (capture mem_rdata, replace only the addressed lane(s) with the stored data, keep the other bits) ->WRITE (mem_we=1, mem_wdata=merged word, done=1) ->IDLE; latency is 3 cycles after accept.
REQ-023 mem_addr SHALL equal the registered addr[ADDR_W-1:2] in READ, MERGE and WRITE, and 0 otherwise.
REQ-024 mem_re and mem_we SHALL never both be 1; each SHALL be high for at most one cycle per request.
REQ-025 mem_wdata SHALL be 0 when mem_we=0.
REQ-026 A new request SHALL be accepted in the cycle after WRITE or ERR (back-to-back: IDLE reached between requests); st_data/st_addr changes while busy SHALL have no effect.
REQ-027 The upper bits of st_data above the store size SHALL be ignored.

Reset
REQ-028 While rst=1: state=IDLE, st_ready=0, busy=0, done=0, misalign=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0, and internal registers are cleared.
REQ-029 Reset asserted in READ, MERGE or WRITE SHALL abandon the store: no mem_we in any cycle after rst is sampled, and no done pulse.
REQ-030 In the first cycle after rst deasserts, st_ready SHALL be 1.

Verification
REQ-031 sb: addr=0x1002, data=0xFFFFFFAB, memory word 0x400 holds 0x11223344 -> mem_re at accept+1, mem_we at accept+3 with mem_addr=0x400 and mem_wdata=0x11AB3344, done at the same cycle.
REQ-032 sh: addr=0x2002, data=0x0000BEEF, memory holds 0xCAFEF00D -> mem_wdata=0xBEEFF00D at accept+3, mem_addr=0x800.
REQ-033 sw: addr=0x3000, data=0xDEADBEEF -> no mem_re, mem_we at accept+1 with mem_wdata=0xDEADBEEF and mem_addr=0xC00, done=1.
REQ-034 sh at 0x1001, sw at 0x1002, and size=11 at 0x1000 -> misalign pulse at accept+1 for each, mem_re=mem_we=0 throughout, st_ready=1 at accept+2.
REQ-035 sb at 0x1003 with rst=1 asserted during MERGE -> no mem_we or done; st_ready=1 in the first cycle after rst deasserts.
REQ-036 st_valid held high with sw, sb, sw queued -> accepts at cycles 0, 2 and 6; exactly three mem_we pulses, at cycles 1, 5 and 7.
